// File: rtl/sched_multi.sv
// sched_multi: multi-machine task scheduler with phase-driven short/long dispatch.
// Optional per-machine deadline watchdog enabled by defining SCHED_DEADLINE_EN.
module sched_multi #(
  parameter int NB_TASKS = 3,
  parameter int NB_PROC  = 2,
  parameter int NB_MACH  = 1
`ifdef SCHED_DEADLINE_EN
  ,
  parameter int MAX_TASK_CYCLES = 20
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NB_PROC-1:0] controllable_sched,
  input  logic [NB_MACH-1:0] end_task,
  input  logic               end_of_cycle,
  output logic               error,
  output logic               _rt_sched_short,
  output logic               _rt_sched_long,
  output logic               _rt_end_task,
  output logic               _rt_end_of_cycle,
  output logic [NB_MACH-1:0] busy,
  output logic [3:0]         done_count
);

  localparam int PW = (NB_PROC > 1) ? $clog2(NB_PROC) : 1;
  localparam logic [3:0] LP_NT = 4'(NB_TASKS);

  logic               r_armed;
  logic               r_error;
  logic [NB_MACH-1:0] r_busy;
  logic [3:0]         r_done;
  logic [3:0]         r_phase [NB_PROC];
  logic [PW-1:0]      r_owner [NB_MACH];

  logic               w_act;
  logic               w_preq;
  logic               w_plong;
  logic [PW-1:0]      w_psel;
  logic               w_mfree;
  logic [NB_MACH-1:0] w_moh;
  logic               w_evalid;
  logic [NB_MACH-1:0] w_eoh;
  logic [PW-1:0]      w_eown;
  logic               w_disp;
  logic               w_eoc;
  logic               w_end;
  logic               w_err_tmo;
  logic               w_err_set;

  // Lowest requesting process and its long/short phase bit
  always_comb begin
    w_preq  = 1'b0;
    w_plong = 1'b0;
    w_psel  = '0;
    for (int p = NB_PROC - 1; p >= 0; p--) begin
      if (controllable_sched[p]) begin
        w_preq  = 1'b1;
        w_psel  = PW'(p);
        w_plong = r_phase[p][2'(p)];
      end
    end
  end

  // Lowest free machine, one-hot
  always_comb begin
    w_mfree = 1'b0;
    w_moh   = '0;
    for (int m = NB_MACH - 1; m >= 0; m--) begin
      if (!r_busy[m]) begin
        w_mfree  = 1'b1;
        w_moh    = '0;
        w_moh[m] = 1'b1;
      end
    end
  end

  // Lowest busy machine reporting completion, and its owner
  always_comb begin
    w_evalid = 1'b0;
    w_eoh    = '0;
    w_eown   = '0;
    for (int m = NB_MACH - 1; m >= 0; m--) begin
      if (end_task[m] && r_busy[m]) begin
        w_evalid = 1'b1;
        w_eoh    = '0;
        w_eoh[m] = 1'b1;
        w_eown   = r_owner[m];
      end
    end
  end

`ifdef SCHED_DEADLINE_EN
  localparam logic [7:0] LP_MAX = 8'(MAX_TASK_CYCLES);

  logic [7:0] r_timer [NB_MACH];

  // A busy machine whose timer ran out without completing is an error
  always_comb begin
    w_err_tmo = 1'b0;
    for (int m = 0; m < NB_MACH; m++) begin
      if (r_busy[m] && (r_timer[m] >= LP_MAX) &&
          !(w_end && w_eoh[m]))
        w_err_tmo = 1'b1;
    end
  end

  // Occupancy timers: restart on dispatch, count while busy
  always_ff @(posedge clk) begin
    for (int m = 0; m < NB_MACH; m++) begin
      if (!rst_n)
        r_timer[m] <= '0;
      else if (w_disp && w_moh[m])
        r_timer[m] <= '0;
      else if (r_busy[m] && (r_timer[m] != LP_MAX))
        r_timer[m] <= r_timer[m] + 8'd1;
    end
  end
`else
  assign w_err_tmo = 1'b0;
`endif

  // Event arbitration: dispatch > end_of_cycle > end_task
  always_comb begin
    w_act  = r_armed & rst_n;
    w_disp = w_act & ~r_error & w_preq & w_mfree;
    w_eoc  = w_act & end_of_cycle & ~w_disp;
    w_end  = w_act & ~r_error & ~w_disp & ~w_eoc & w_evalid;
    w_err_set = (w_eoc && (r_done < LP_NT))
              | ((|controllable_sched) && !w_mfree)
              | (w_act && (|(end_task & ~r_busy)))
              | w_err_tmo;
  end

  // Scheduler state: arming, error, occupancy, owners, counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_error <= 1'b0;
      r_busy  <= '0;
      r_done  <= '0;
      for (int p = 0; p < NB_PROC; p++)
        r_phase[p] <= '0;
      for (int m = 0; m < NB_MACH; m++)
        r_owner[m] <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_err_set)
        r_error <= 1'b1;
      r_busy <= (r_busy | (w_disp ? w_moh : '0))
              & ~(w_end ? w_eoh : '0);
      for (int m = 0; m < NB_MACH; m++) begin
        if (w_disp && w_moh[m])
          r_owner[m] <= w_psel;
      end
      for (int p = 0; p < NB_PROC; p++) begin
        if (w_end && (w_eown == PW'(p)))
          r_phase[p] <= r_phase[p] + 4'd1;
      end
      if (w_eoc)
        r_done <= '0;
      else if (w_end && (r_done != LP_NT))
        r_done <= r_done + 4'd1;
    end
  end

  assign error            = r_error;
  assign busy             = r_busy;
  assign done_count       = r_done;
  assign _rt_sched_short  = w_disp & ~w_plong;
  assign _rt_sched_long   = w_disp & w_plong;
  assign _rt_end_task     = w_end;
  assign _rt_end_of_cycle = w_eoc;

endmodule

// File: tb/tb_sched_multi.sv
// tb_sched_multi: directed checks of sched_multi with one and two machines.
// Expected values are hand-derived from the scheduling rules.
module tb_sched_multi;

  logic       clk;
  logic       rst1, rst2;
  logic [1:0] sched1, sched2;
  logic [0:0] et1;
  logic [1:0] et2;
  logic       eoc1, eoc2;
  logic       err1, rs1, rl1, re1, rc1;
  logic       err2, rs2, rl2, re2, rc2;
  logic [0:0] busy1;
  logic [1:0] busy2;
  logic [3:0] done1, done2;

  int n_tests;
  int n_fail;

  sched_multi #(.NB_TASKS(3), .NB_PROC(2), .NB_MACH(1)) u_d1 (
    .clk(clk), .rst_n(rst1),
    .controllable_sched(sched1), .end_task(et1),
    .end_of_cycle(eoc1), .error(err1),
    ._rt_sched_short(rs1), ._rt_sched_long(rl1),
    ._rt_end_task(re1), ._rt_end_of_cycle(rc1),
    .busy(busy1), .done_count(done1)
  );

  sched_multi #(.NB_TASKS(3), .NB_PROC(2), .NB_MACH(2)) u_d2 (
    .clk(clk), .rst_n(rst2),
    .controllable_sched(sched2), .end_task(et2),
    .end_of_cycle(eoc2), .error(err2),
    ._rt_sched_short(rs2), ._rt_sched_long(rl2),
    ._rt_end_task(re2), ._rt_end_of_cycle(rc2),
    .busy(busy2), .done_count(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    sched1 = '0; et1 = '0; eoc1 = 1'b0;
    sched2 = '0; et2 = '0; eoc2 = 1'b0;
  endtask

  task automatic set1(input logic [1:0] s, input logic e,
                      input logic c);
    sched1 = s; et1[0] = e; eoc1 = c;
    #2;
  endtask

  task automatic set2(input logic [1:0] s, input logic [1:0] e,
                      input logic c);
    sched2 = s; et2 = e; eoc2 = c;
    #2;
  endtask

  task automatic do_reset1();
    rst1 = 1'b0;
    tick(); tick();
    rst1 = 1'b1;
    tick();
  endtask

  task automatic do_reset2();
    rst2 = 1'b0;
    tick(); tick();
    rst2 = 1'b1;
    tick();
  endtask

  task automatic run_task1();
    set1(2'b01, 1'b0, 1'b0); tick();
    set1(2'b00, 1'b1, 1'b0); tick();
  endtask

  task automatic test_reset();
    rst1 = 1'b0;
    tick();
    set1(2'b11, 1'b1, 1'b1);
    n_tests++;
    if ({rs1, rl1, re1, rc1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_rt: got %b want 0000", {rs1, rl1, re1, rc1});
    end
    n_tests++;
    if ({err1, busy1, done1} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_state: err=%b busy=%b done=%0d want 0", err1, busy1, done1);
    end
    rst1 = 1'b1;
    #1;
    n_tests++;
    if ({rs1, rl1, re1, rc1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL unarmed_rt: got %b want 0000", {rs1, rl1, re1, rc1});
    end
    tick();
    n_tests++;
    if ({err1, busy1} !== 2'b00) begin
      n_fail++;
      $display("FAIL unarmed_state: err=%b busy=%b want 0 0", err1, busy1);
    end
  endtask

  task automatic test_full_cycle();
    logic exp_l;
    do_reset1();
    for (int i = 0; i < 3; i++) begin
      exp_l = (i == 1);
      set1(2'b01, 1'b0, 1'b0);
      n_tests++;
      if ({rs1, rl1} !== {~exp_l, exp_l}) begin
        n_fail++;
        $display("FAIL full_disp%0d: short/long=%b%b want %b%b", i, rs1, rl1, ~exp_l, exp_l);
      end
      tick();
      n_tests++;
      if (busy1 !== 1'b1) begin
        n_fail++;
        $display("FAIL full_busy%0d: got %b want 1", i, busy1);
      end
      set1(2'b00, 1'b1, 1'b0);
      n_tests++;
      if (re1 !== 1'b1) begin
        n_fail++;
        $display("FAIL full_end%0d: got %b want 1", i, re1);
      end
      tick();
      n_tests++;
      if ({busy1, done1} !== {1'b0, 4'(i + 1)}) begin
        n_fail++;
        $display("FAIL full_done%0d: busy=%b done=%0d want 0 %0d", i, busy1, done1, i + 1);
      end
    end
    set1(2'b00, 1'b0, 1'b1);
    n_tests++;
    if (rc1 !== 1'b1) begin
      n_fail++;
      $display("FAIL full_eoc: got %b want 1", rc1);
    end
    tick();
    n_tests++;
    if ({err1, done1} !== 5'd0) begin
      n_fail++;
      $display("FAIL full_after: err=%b done=%0d want 0 0", err1, done1);
    end
  endtask

  task automatic test_eoc_short();
    do_reset1();
    run_task1();
    run_task1();
    set1(2'b00, 1'b0, 1'b1);
    n_tests++;
    if ({rc1, err1} !== 2'b10) begin
      n_fail++;
      $display("FAIL short_eoc: rt_eoc=%b err=%b want 1 0", rc1, err1);
    end
    tick();
    n_tests++;
    if (err1 !== 1'b1) begin
      n_fail++;
      $display("FAIL short_err: got %b want 1", err1);
    end
    set1(2'b01, 1'b0, 1'b0);
    n_tests++;
    if ({rs1, rl1} !== 2'b00) begin
      n_fail++;
      $display("FAIL err_nodisp: got %b%b want 00", rs1, rl1);
    end
    tick();
    set1(2'b00, 1'b0, 1'b1);
    n_tests++;
    if (rc1 !== 1'b1) begin
      n_fail++;
      $display("FAIL err_eoc: got %b want 1", rc1);
    end
    tick();
  endtask

  task automatic test_busy_req();
    do_reset1();
    set1(2'b01, 1'b0, 1'b0); tick();
    set1(2'b10, 1'b0, 1'b0);
    n_tests++;
    if ({rs1, rl1} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_req_rt: got %b%b want 00", rs1, rl1);
    end
    tick();
    n_tests++;
    if (err1 !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_req_err: got %b want 1", err1);
    end
    set1(2'b00, 1'b1, 1'b0);
    n_tests++;
    if (re1 !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_req_end: got %b want 0", re1);
    end
    tick();
    n_tests++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_req_busy: got %b want 1", busy1);
    end
    set1(2'b01, 1'b0, 1'b0);
    n_tests++;
    if ({rs1, rl1} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_req_nodisp: got %b%b want 00", rs1, rl1);
    end
    tick();
  endtask

  task automatic test_spurious_end();
    do_reset1();
    set1(2'b00, 1'b1, 1'b0);
    n_tests++;
    if (re1 !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_rt: got %b want 0", re1);
    end
    tick();
    n_tests++;
    if (err1 !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_err: got %b want 1", err1);
    end
  endtask

  task automatic test_phase_wrap();
    logic exp_l;
    do_reset1();
    for (int k = 0; k <= 16; k++) begin
      exp_l = ((k % 16) % 2) == 1;
      set1(2'b01, 1'b0, 1'b0);
      n_tests++;
      if ({rs1, rl1} !== {~exp_l, exp_l}) begin
        n_fail++;
        $display("FAIL phase_k%0d: short/long=%b%b want %b%b", k, rs1, rl1, ~exp_l, exp_l);
      end
      tick();
      set1(2'b00, 1'b1, 1'b0);
      tick();
    end
    n_tests++;
    if ({err1, done1} !== {1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL phase_sat: err=%b done=%0d want 0 3", err1, done1);
    end
  endtask

  task automatic test_reset_busy();
    do_reset1();
    run_task1();
    set1(2'b01, 1'b0, 1'b0); tick();
    rst1 = 1'b0;
    tick();
    n_tests++;
    if ({busy1, done1} !== 5'd0) begin
      n_fail++;
      $display("FAIL rstbusy_state: busy=%b done=%0d want 0 0", busy1, done1);
    end
    rst1 = 1'b1;
    tick();
    set1(2'b01, 1'b0, 1'b0);
    n_tests++;
    if ({rs1, rl1} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstbusy_phase: short/long=%b%b want 10", rs1, rl1);
    end
    tick();
  endtask

  task automatic test_two_mach();
    do_reset2();
    set2(2'b11, 2'b00, 1'b0);
    n_tests++;
    if ({rs2, rl2} !== 2'b10) begin
      n_fail++;
      $display("FAIL two_d0: short/long=%b%b want 10", rs2, rl2);
    end
    tick();
    n_tests++;
    if (busy2 !== 2'b01) begin
      n_fail++;
      $display("FAIL two_busy0: got %b want 01", busy2);
    end
    set2(2'b10, 2'b00, 1'b0);
    n_tests++;
    if ({rs2, rl2} !== 2'b10) begin
      n_fail++;
      $display("FAIL two_d1: short/long=%b%b want 10", rs2, rl2);
    end
    tick();
    n_tests++;
    if (busy2 !== 2'b11) begin
      n_fail++;
      $display("FAIL two_busy1: got %b want 11", busy2);
    end
    set2(2'b00, 2'b10, 1'b0);
    n_tests++;
    if (re2 !== 1'b1) begin
      n_fail++;
      $display("FAIL two_end1: got %b want 1", re2);
    end
    tick();
    n_tests++;
    if ({busy2, done2} !== {2'b01, 4'd1}) begin
      n_fail++;
      $display("FAIL two_after1: busy=%b done=%0d want 01 1", busy2, done2);
    end
    set2(2'b10, 2'b00, 1'b0); tick();
    set2(2'b00, 2'b10, 1'b0); tick();
    set2(2'b10, 2'b00, 1'b0);
    n_tests++;
    if ({rs2, rl2} !== 2'b01) begin
      n_fail++;
      $display("FAIL two_owner: short/long=%b%b want 01", rs2, rl2);
    end
    tick();
    set2(2'b00, 2'b11, 1'b0);
    n_tests++;
    if (re2 !== 1'b1) begin
      n_fail++;
      $display("FAIL two_endboth: got %b want 1", re2);
    end
    tick();
    n_tests++;
    if ({err2, busy2} !== 3'b010) begin
      n_fail++;
      $display("FAIL two_lowend: err=%b busy=%b want 0 10", err2, busy2);
    end
  endtask

  task automatic test_eoc_end();
    do_reset1();
    run_task1();
    run_task1();
    run_task1();
    set1(2'b01, 1'b0, 1'b0); tick();
    set1(2'b00, 1'b1, 1'b1);
    n_tests++;
    if ({rc1, re1, rs1, rl1} !== 4'b1000) begin
      n_fail++;
      $display("FAIL eoc_end_rt: eoc/end/s/l=%b want 1000", {rc1, re1, rs1, rl1});
    end
    tick();
    n_tests++;
    if ({err1, busy1, done1} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL eoc_end_state: err=%b busy=%b done=%0d want 0 1 0", err1, busy1, done1);
    end
    set1(2'b00, 1'b1, 1'b0);
    tick();
    n_tests++;
    if ({busy1, done1} !== {1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL eoc_end_later: busy=%b done=%0d want 0 1", busy1, done1);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst1 = 1'b0; rst2 = 1'b0;
    sched1 = '0; et1 = '0; eoc1 = 1'b0;
    sched2 = '0; et2 = '0; eoc2 = 1'b0;
    test_reset();
    test_full_cycle();
    test_eoc_short();
    test_busy_req();
    test_spurious_end();
    test_phase_wrap();
    test_reset_busy();
    test_two_mach();
    test_eoc_end();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sched_multi.md
SCHED_MULTI -- requirements
Module: sched_multi

Interface
REQ-001 The block SHALL have parameter NB_TASKS, default 3, meaning the minimum number of completed tasks per cycle (range 1..15).
REQ-002 The block SHALL have parameter NB_PROC, default 2, meaning the number of schedulable processes (range 1..8).
REQ-003 The block SHALL have parameter NB_MACH, default 1, meaning the number of identical machines (range 1..4).
REQ-004 The block SHALL have the following ports, one per line:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- controllable_sched  input  NB_PROC  per-process schedule request from the controller.
- end_task  input  NB_MACH  per-machine task-completion event.
- end_of_cycle  input  1  cycle-boundary event.
- error  output  1  sticky error flag.
- _rt_sched_short  output  1  a short task is dispatched this cycle.
- _rt_sched_long  output  1  a long task is dispatched this cycle.
- _rt_end_task  output  1  a task completion is accepted this cycle.
- _rt_end_of_cycle  output  1  a cycle boundary is accepted this cycle.
- busy  output  NB_MACH  machine-occupied flags.
- done_count  output  4  tasks completed in the current cycle (saturating).

Function
REQ-005 The block SHALL hold an armed flag; while armed=0, all _rt_* outputs SHALL be 0, and armed SHALL set on the first edge after reset release.
REQ-006 Each process p SHALL hold a 4-bit phase counter that increments modulo 16 (15->0) when a task of p is accepted as ended.
REQ-007 The selected process SHALL be the lowest index p with controllable_sched[p]=1; the selected machine SHALL be the lowest index m with busy[m]=0.
REQ-008 A dispatch SHALL occur when armed, ~error, a process is requested, and a free machine exists; it is long iff phase_p[p mod 4]=1, else short; exactly one of _rt_sched_short/_rt_sched_long SHALL assert.
REQ-009 On a dispatch, busy[m] SHALL set and machine m SHALL record owner p on the next edge (1-cycle latency).
REQ-010 _rt_end_of_cycle SHALL assert when armed, end_of_cycle=1, and no dispatch occurs this cycle.
REQ-011 _rt_end_task SHALL assert when armed, ~error, no dispatch, no _rt_end_of_cycle, and end_task[m]=1 for some busy m; the lowest such m is accepted: busy[m] clears, the owner's phase increments, and done_count increments, saturating at NB_TASKS.
REQ-012 Event priority SHALL be dispatch > end_of_cycle > end_task; at most one _rt_* output SHALL be high per cycle.
REQ-013 On an accepted end_of_cycle, done_count SHALL return to 0; if end_task is also accepted in the same cycle, the clear wins.
REQ-014 error SHALL set, and remain set until reset, on any of:
- accepted end_of_cycle with done_count < NB_TASKS;
- any controllable_sched bit high while all machines are busy;
- end_task[m]=1 while busy[m]=0 (armed only).
REQ-015 When error=1, dispatch and end_task SHALL be suppressed; _rt_end_of_cycle SHALL remain functional.

Reset
REQ-016 When rst_n=0 at a rising edge, armed, busy, done_count, error, all phase counters, and all owners SHALL be cleared to 0.
REQ-017 A reset during an occupied machine SHALL discard the task with no phase increment.
REQ-018 All _rt_* outputs SHALL read 0 during reset and in the first cycle after reset.

Configuration
REQ-019 With SCHED_DEADLINE_EN defined, each machine SHALL have an 8-bit occupancy timer (parameter MAX_TASK_CYCLES, default 20) that clears on dispatch and increments while busy; error SHALL set when a timer reaches MAX_TASK_CYCLES without end_task.
REQ-020 Without SCHED_DEADLINE_EN, no timers SHALL exist, and occupancy duration SHALL never cause error.

Verification
REQ-021 The bench SHALL cover the following directed scenarios with defaults (NB_TASKS=3, NB_PROC=2, NB_MACH=1):
- Dispatch p0 three times, each followed by end_task, then end_of_cycle -> error stays 0 and done_count returns to 0.
- Two tasks, then end_of_cycle -> _rt_end_of_cycle=1, and error=1 on the next cycle.
- Dispatch p0, then request p1 while busy[0]=1 -> error=1, and no further _rt_sched_* outputs.
- p0 phase at 1 -> _rt_sched_long on the second dispatch; 16 completions wrap phase to 0, giving a short dispatch.
- NB_MACH=2, both requests in one cycle -> single dispatch of p0 to machine 0; the next cycle dispatches p1 to machine 1.
- end_of_cycle and end_task in the same cycle -> only _rt_end_of_cycle=1, and done_count=0.
